// File: rtl/seq_window_pkg.sv
// ---------------------------------------------------------------------------
// seq_window_pkg
// Shared types and elaboration-time helpers for the nucleotide window
// shifter. It provides:
//   state_t       - FSM encoding (IDLE, REALIGN)
//   calc_reg_w    - window register width: data word plus symbol tail
//   calc_step_w   - width needed to hold a per-cycle shift of 0..STEP_MAX
//   sym_ceil_div  - ceiling division. For a realign delta it gives the
//                   number of REALIGN cycles.
// ---------------------------------------------------------------------------
package seq_window_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        REALIGN = 1'b1
    } state_t;

    function automatic int calc_reg_w(input int data_w, input int sym_w,
                                      input int ext_syms);
        return data_w + ext_syms * sym_w;
    endfunction

    function automatic int calc_step_w(input int step_max);
        return $clog2(step_max + 1);
    endfunction

    function automatic int sym_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/seq_window_shifter_barrel_shift.sv
// ---------------------------------------------------------------------------
// sym_barrel_shift
// Combinational logical right shift by 0..STEP_MAX whole symbols. Zeros fill
// the vacated top bits. An amount above STEP_MAX yields all zeros.
// Ports:
//   data   in  REG_W   word to shift
//   amt    in  STEP_W  shift amount in symbols
//   result out REG_W   shifted word
// ---------------------------------------------------------------------------
module sym_barrel_shift
    import seq_window_pkg::*;
#(
    parameter  int REG_W    = 534,
    parameter  int SYM_W    = 2,
    parameter  int STEP_MAX = 4,
    localparam int STEP_W   = calc_step_w(STEP_MAX)
) (
    input  logic [REG_W-1:0]  data,
    input  logic [STEP_W-1:0] amt,
    output logic [REG_W-1:0]  result
);

    always_comb begin
        result = '0;
        for (int k = 0; k <= STEP_MAX; k++) begin
            if (amt == STEP_W'(k)) begin
                result = data >> (k * SYM_W);
            end
        end
    end

endmodule

// File: rtl/seq_window_shifter.sv
// ---------------------------------------------------------------------------
// seq_window_shifter
// Nucleotide window shift register for the seed/extension datapath. It holds
// one packed DATA_W-bit word plus an EXT_SYMS-symbol tail. The window advances
// one symbol per shift. A realign moves it by (shift_no - base) symbols over
// several cycles, at up to STEP_MAX symbols per cycle.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        write in_data (accepted only while load_ready)
//   load_ready  high in IDLE when not in reset
//   in_data     packed symbols, symbol 0 in the LSBs
//   shift       advance the window by one symbol (IDLE only)
//   mark        capture shift_no into the base register (any state)
//   realign     start a realign by shift_no - base (IDLE only)
//   shift_no    hit position in symbols
//   out_data    low DATA_W bits of the window
//   busy        realign in progress
//   done        one-cycle pulse when a realign completes
//   err         one-cycle pulse when shift_no < base; delta clamped to 0
//   sym_count   saturating count of symbols shifted since the last load
// ---------------------------------------------------------------------------
module seq_window_shifter
    import seq_window_pkg::*;
#(
    parameter int DATA_W   = 512,
    parameter int SYM_W    = 2,
    parameter int EXT_SYMS = 11,
    parameter int STEP_MAX = 4,
    parameter int CNT_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    output logic              load_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              shift,
    input  logic              mark,
    input  logic              realign,
    input  logic [CNT_W-1:0]  shift_no,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  sym_count
);

    localparam int TAIL_W = EXT_SYMS * SYM_W;
    localparam int REG_W  = calc_reg_w(DATA_W, SYM_W, EXT_SYMS);
    localparam int STEP_W = calc_step_w(STEP_MAX);

    state_t             state;
    state_t             state_nxt;
    logic [REG_W-1:0]   win;
    logic [REG_W-1:0]   bs_in;
    logic [REG_W-1:0]   bs_out;
    logic [STEP_W-1:0]  bs_amt;
    logic [STEP_W-1:0]  step;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   base;
    logic [CNT_W-1:0]   delta;
    logic               clamp;
    logic               last;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign clamp = (shift_no < base);
    assign delta = clamp ? '0 : (shift_no - base);
    assign step  = (rem < CNT_W'(STEP_MAX)) ? rem[STEP_W-1:0] : STEP_W'(STEP_MAX);
    assign last  = (rem <= CNT_W'(STEP_MAX));

    // One shifter serves both paths. In IDLE it handles the optional
    // single-symbol shift of either the current window or the freshly loaded
    // word. In REALIGN it applies the per-cycle step.
    always_comb begin
        bs_in  = win;
        bs_amt = '0;
        if (state == IDLE) begin
            if (load) begin
                bs_in = shift ? {in_data, win[TAIL_W-1:0]} : REG_W'(in_data);
            end
            bs_amt = shift ? STEP_W'(1) : '0;
        end else begin
            bs_amt = step;
        end
    end

    sym_barrel_shift #(
        .REG_W    (REG_W),
        .SYM_W    (SYM_W),
        .STEP_MAX (STEP_MAX)
    ) u_shift (
        .data   (bs_in),
        .amt    (bs_amt),
        .result (bs_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (realign) state_nxt = REALIGN;
            REALIGN: if (last)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= '0;
            base      <= '0;
            rem       <= '0;
            sym_count <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // base is sampled before the update, so a realign in the same
            // cycle still uses the old base.
            if (mark) begin
                base <= shift_no;
            end
            if (state == IDLE) begin
                win <= bs_out;
                if (load && shift) begin
                    sym_count <= CNT_W'(1);
                end else if (load) begin
                    sym_count <= '0;
                end else if (shift) begin
                    sym_count <= sat_add(sym_count, CNT_W'(1));
                end
                if (realign) begin
                    rem <= delta;
                    err <= clamp;
                end
            end else begin
                win       <= bs_out;
                rem       <= rem - CNT_W'(step);
                sym_count <= sat_add(sym_count, CNT_W'(step));
                if (last) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign out_data   = win[DATA_W-1:0];
    assign busy       = (state == REALIGN);
    assign load_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_seq_window_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_window_shifter
// Directed bench for seq_window_shifter with default parameters. Expected
// values are hand-derived from the window/realign behaviour.
// ---------------------------------------------------------------------------
module tb_seq_window_shifter;

    logic         clk;
    logic         rst;
    logic         load;
    logic         load_ready;
    logic [511:0] in_data;
    logic         shift;
    logic         mark;
    logic         realign;
    logic [8:0]   shift_no;
    logic [511:0] out_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [8:0]   sym_count;

    int errors = 0;
    int checks = 0;

    seq_window_shifter dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_ready (load_ready),
        .in_data    (in_data),
        .shift      (shift),
        .mark       (mark),
        .realign    (realign),
        .shift_no   (shift_no),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sym_count  (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [511:0] d0, d1, d2, d3, snap;
    logic [533:0] ls_model;
    int n;

    initial begin
        d0 = {8{64'hFEDC_BA98_7654_0123}};
        d1 = {16{32'h1357_9BDF}};
        d2 = {8{64'h0F1E_2D3C_4B5A_6978}};
        d3 = {16{32'hDEAD_BEEF}};
        rst = 1'b1; load = 1'b0; in_data = '0; shift = 1'b0;
        mark = 1'b0; realign = 1'b0; shift_no = '0;
        tick();
        tick();

        // reset state
        check("rst_out", out_data, '0);
        check("rst_cnt", 512'(sym_count), '0);
        check("rst_busy", 512'(busy), '0);
        check("rst_done", 512'(done), '0);
        check("rst_err", 512'(err), '0);
        check("rst_ready", 512'(load_ready), '0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 512'(load_ready), 512'd1);

        // plain load
        load = 1'b1; in_data = d0;
        tick();
        load = 1'b0;
        check("load_out", out_data, d0);
        check("load_cnt", 512'(sym_count), '0);
        check("load_ready", 512'(load_ready), 512'd1);

        // three single-symbol shifts
        shift = 1'b1;
        tick(); tick(); tick();
        shift = 1'b0;
        check("shift3_out", out_data, d0 >> 6);
        check("shift3_cnt", 512'(sym_count), 512'd3);

        // load & shift: new word lands above the old tail, then one symbol out
        load = 1'b1; shift = 1'b1; in_data = d1;
        tick();
        load = 1'b0; shift = 1'b0;
        ls_model = {d1, d0[27:6]} >> 2;
        check("ldsh_out", out_data, ls_model[511:0]);
        check("ldsh_low20", 512'(out_data[19:0]), 512'(d0[27:8]));
        check("ldsh_cnt", 512'(sym_count), 512'd1);

        // mark 5, realign to 15: delta 10 -> steps 4,4,2
        snap = out_data;
        mark = 1'b1; shift_no = 9'd5;
        tick();
        mark = 1'b0; realign = 1'b1; shift_no = 9'd15;
        tick();
        realign = 1'b0;
        check("ra10_err", 512'(err), '0);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("ra10_busy_cycles", 512'(n), 512'd3);
        check("ra10_done", 512'(done), 512'd1);
        check("ra10_ready", 512'(load_ready), 512'd1);
        check("ra10_out", out_data, ls_model[531:20]);
        check("ra10_cnt", 512'(sym_count), 512'd11);
        snap = out_data;
        tick();
        check("ra10_done_clear", 512'(done), '0);

        // clamped realign: base 7, shift_no 3
        mark = 1'b1; shift_no = 9'd7;
        tick();
        mark = 1'b0; realign = 1'b1; shift_no = 9'd3;
        tick();
        realign = 1'b0;
        check("clamp_err", 512'(err), 512'd1);
        check("clamp_busy", 512'(busy), 512'd1);
        tick();
        check("clamp_err_clear", 512'(err), '0);
        check("clamp_busy_clear", 512'(busy), '0);
        check("clamp_done", 512'(done), 512'd1);
        check("clamp_out", out_data, snap);
        check("clamp_cnt", 512'(sym_count), 512'd11);

        // load + realign together, delta 13-7 = 6; inputs ignored while busy
        load = 1'b1; in_data = d2; realign = 1'b1; shift_no = 9'd13;
        tick();
        load = 1'b1; in_data = d3; shift = 1'b1; realign = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            check("busy_ready_low", 512'(load_ready), '0);
            n++;
            tick();
        end
        load = 1'b0; shift = 1'b0; realign = 1'b0;
        check("ldra_busy_cycles", 512'(n), 512'd2);
        check("ldra_done", 512'(done), 512'd1);
        check("ldra_out", out_data, d2 >> 12);
        check("ldra_cnt", 512'(sym_count), 512'd6);

        // reset in the 2nd REALIGN cycle of a delta-12 realign
        realign = 1'b1; shift_no = 9'd19;
        tick();
        realign = 1'b0;
        check("abort_busy1", 512'(busy), 512'd1);
        tick();
        check("abort_busy2", 512'(busy), 512'd1);
        rst = 1'b1;
        tick();
        check("abort_out", out_data, '0);
        check("abort_cnt", 512'(sym_count), '0);
        check("abort_busy", 512'(busy), '0);
        check("abort_done", 512'(done), '0);
        check("abort_ready", 512'(load_ready), '0);
        rst = 1'b0;
        tick();
        check("abort_no_done", 512'(done), '0);
        load = 1'b1; in_data = d1;
        tick();
        load = 1'b0;
        check("post_abort_load", out_data, d1);
        check("post_abort_cnt", 512'(sym_count), '0);

        // saturation: base is 0 after reset, delta 511 -> 128 cycles
        realign = 1'b1; shift_no = 9'd511;
        tick();
        realign = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("sat_busy_cycles", 512'(n), 512'd128);
        check("sat_done", 512'(done), 512'd1);
        check("sat_cnt", 512'(sym_count), 512'd511);
        check("sat_out", out_data, '0);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        check("sat_hold", 512'(sym_count), 512'd511);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
